// File: rtl/vend_pkg.sv
// Shared types, widths and coin values for the vending coin-credit controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_t;

    localparam int CREDIT_W = 3;

    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] ONE  = 2'd2;

    // Value of one cycle's coin inputs in half-units, one bit wider than credit
    // so that credit + value can be range-checked without wrapping.
    function automatic logic [CREDIT_W:0] coin_value(input logic half_in, input logic one_in);
        logic [CREDIT_W:0] v_half;
        logic [CREDIT_W:0] v_one;
        v_half = half_in ? {2'b00, HALF} : 4'd0;
        v_one  = one_in  ? {2'b00, ONE}  : 4'd0;
        return v_half + v_one;
    endfunction

endpackage

// File: rtl/vend_rr_arb2.sv
// Two-request round-robin arbiter: one-hot grant while enabled, pointer moves
// to favour the other item after every grant.
module vend_rr_arb2
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours item 0, ptr_q = 1 favours item 1
    logic ptr_q;
    logic ptr_d;

    // Grant selection and next pointer value
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
        if (gnt != 2'b00) begin
            // granted item 0 -> favour 1, granted item 1 -> favour 0
            ptr_d = gnt[0];
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Coin-credit sequencer: accumulates credit, arbitrates product selects,
// hands a vend request over valid/ready, then pays change one half-unit pulse
// every second cycle. All outputs come straight from flops.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic [1:0]          sel_req,
    input  logic                cancel,
    input  logic                vend_ready,
    output logic                vend_valid,
    output logic                vend_item,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int                 TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]  MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMO_W-1:0]    timer_q, timer_d;
    logic                vend_valid_q, vend_valid_d;
    logic                vend_item_q, vend_item_d;
    logic                change_pulse_q, change_pulse_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   value_s;
    logic [CREDIT_W:0]   sum_s;
    logic                coin_any_s;
    logic                coin_ok_s;
    logic                arb_en_s;
    logic [1:0]          gnt_s;
    logic                grant_s;
    logic [CREDIT_W-1:0] remain_s;

    // A grant needs enough credit before this cycle's coins and no cancel.
    assign arb_en_s = (state_q == CREDIT) && !cancel && (credit_q >= PRICE_C);
    assign grant_s  = (gnt_s != 2'b00);

    vend_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (sel_req),
        .en    (arb_en_s),
        .gnt   (gnt_s)
    );

    // Next-state, credit, timeout and registered-output computation
    always_comb begin
        value_s        = coin_value(coin_half, coin_one);
        sum_s          = {1'b0, credit_q} + value_s;
        coin_any_s     = (value_s != 4'd0);
        remain_s       = credit_q - PRICE_C;
        coin_ok_s      = 1'b0;
        state_d        = state_q;
        credit_d       = credit_q;
        timer_d        = timer_q;
        vend_item_d    = vend_item_q;
        coin_reject_d  = 1'b0;

        // Coins are only taken while collecting credit, and only whole-cycle.
        if ((state_q == IDLE) || (state_q == CREDIT)) begin
            if (coin_any_s && (sum_s <= MAX_C)) begin
                coin_ok_s = 1'b1;
                credit_d  = sum_s[CREDIT_W-1:0];
            end else begin
                coin_reject_d = coin_any_s;
            end
        end else begin
            coin_reject_d = coin_any_s;
        end

        case (state_q)
            IDLE: begin
                if (coin_ok_s) begin
                    state_d = CREDIT;
                    timer_d = {TMO_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            CREDIT: begin
                if (cancel) begin
                    state_d = CHANGE;
                end else if (grant_s) begin
                    state_d     = VEND;
                    vend_item_d = gnt_s[1];
                    timer_d     = {TMO_W{1'b0}};
                end else if (coin_ok_s) begin
                    timer_d = {TMO_W{1'b0}};
                end else if (timer_q == TMO_LAST) begin
                    state_d = CHANGE;
                end else begin
                    timer_d = timer_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            VEND: begin
                // vend_valid is high throughout VEND, so ready alone completes it
                if (vend_ready) begin
                    credit_d = remain_s;
                    state_d  = (remain_s != {CREDIT_W{1'b0}}) ? CHANGE : IDLE;
                end else begin
                    state_d = VEND;
                end
            end
            CHANGE: begin
                if (change_pulse_q) begin
                    credit_d = credit_q - {{(CREDIT_W-1){1'b0}}, 1'b1};
                    state_d  = (credit_q == {{(CREDIT_W-1){1'b0}}, 1'b1}) ? IDLE : CHANGE;
                end else begin
                    state_d = CHANGE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vend_valid_d   = (state_d == VEND);
        busy_d         = (state_d == VEND) || (state_d == CHANGE);
        // Pulse on the first CHANGE cycle, then alternate.
        change_pulse_d = (state_d == CHANGE) && !((state_q == CHANGE) && change_pulse_q);
    end

    // State, credit and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= {CREDIT_W{1'b0}};
            timer_q        <= {TMO_W{1'b0}};
            vend_valid_q   <= 1'b0;
            vend_item_q    <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller with default parameters
// (PRICE 3, MAX_CREDIT 6, TIMEOUT 16).
module tb_vend_controller;

    logic       clk;
    logic       reset;
    logic       coin_half;
    logic       coin_one;
    logic [1:0] sel_req;
    logic       cancel;
    logic       vend_ready;
    logic       vend_valid;
    logic       vend_item;
    logic       change_pulse;
    logic       coin_reject;
    logic [2:0] credit;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    vend_controller dut (
        .clk          (clk),
        .reset        (reset),
        .coin_half    (coin_half),
        .coin_one     (coin_one),
        .sel_req      (sel_req),
        .cancel       (cancel),
        .vend_ready   (vend_ready),
        .vend_valid   (vend_valid),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected output packing: {vend_valid, vend_item, change_pulse, coin_reject, credit[2:0], busy}
    typedef struct {
        logic       ch;
        logic       co;
        logic [1:0] sel;
        logic       can;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    function automatic vec_t mk(input logic ch, input logic co, input logic [1:0] sel,
                                input logic can, input logic rdy,
                                input logic vv, input logic vi, input logic cp,
                                input logic cr, input logic [2:0] cred, input logic bz);
        vec_t v;
        v.ch  = ch;
        v.co  = co;
        v.sel = sel;
        v.can = can;
        v.rdy = rdy;
        v.exp = {vv, vi, cp, cr, cred, bz};
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {vend_valid, vend_item, change_pulse, coin_reject, credit, busy};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b (vv vi cp cr credit busy), expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        coin_half  = 1'b0;
        coin_one   = 1'b0;
        sel_req    = 2'b00;
        cancel     = 1'b0;
        vend_ready = 1'b0;
    endtask

    // drive one vector on the falling edge, compare one cycle later
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        coin_half  = v.ch;
        coin_one   = v.co;
        sel_req    = v.sel;
        cancel     = v.can;
        vend_ready = v.rdy;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), outs(), sb.pop_front());
    endtask

    initial begin
        int  cnt;
        int  pulses;
        bit  done;

        // two vends with both requests: item 0 then item 1; insufficient credit ignored
        vecs.push_back(mk(0,1,2'b00,0,0, 0,0,0,0,3'd2,0));
        vecs.push_back(mk(0,0,2'b11,0,1, 0,0,0,0,3'd2,0));
        vecs.push_back(mk(1,0,2'b11,0,0, 0,0,0,0,3'd3,0));
        vecs.push_back(mk(0,0,2'b11,0,0, 1,0,0,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b11,0,1, 0,0,0,0,3'd0,0));
        vecs.push_back(mk(0,0,2'b11,0,0, 0,0,0,0,3'd0,0));
        vecs.push_back(mk(0,1,2'b11,0,0, 0,0,0,0,3'd2,0));
        vecs.push_back(mk(1,0,2'b11,0,0, 0,0,0,0,3'd3,0));
        vecs.push_back(mk(0,0,2'b11,0,0, 1,1,0,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b00,0,1, 0,1,0,0,3'd0,0));
        // credit 4, item 0, ready two cycles later, one change pulse
        vecs.push_back(mk(0,1,2'b00,0,0, 0,1,0,0,3'd2,0));
        vecs.push_back(mk(0,1,2'b00,0,0, 0,1,0,0,3'd4,0));
        vecs.push_back(mk(0,0,2'b01,0,0, 1,0,0,0,3'd4,1));
        vecs.push_back(mk(0,0,2'b00,1,0, 1,0,0,0,3'd4,1));
        vecs.push_back(mk(0,0,2'b00,0,1, 0,0,1,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd0,0));
        // overflow rejects, cancel from 6, coin during CHANGE rejected
        vecs.push_back(mk(0,1,2'b00,0,0, 0,0,0,0,3'd2,0));
        vecs.push_back(mk(0,1,2'b00,0,0, 0,0,0,0,3'd4,0));
        vecs.push_back(mk(1,0,2'b00,0,0, 0,0,0,0,3'd5,0));
        vecs.push_back(mk(0,1,2'b00,0,0, 0,0,0,1,3'd5,0));
        vecs.push_back(mk(1,0,2'b00,0,0, 0,0,0,0,3'd6,0));
        vecs.push_back(mk(1,0,2'b00,0,0, 0,0,0,1,3'd6,0));
        vecs.push_back(mk(0,0,2'b00,1,0, 0,0,1,0,3'd6,1));
        vecs.push_back(mk(1,0,2'b00,0,0, 0,0,0,1,3'd5,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,1,0,3'd5,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd4,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,1,0,3'd4,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,1,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,1,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,1,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,0,0,0,3'd0,0));
        // both coins at once (3), then again to 6; vend item 1; coin in VEND rejected
        vecs.push_back(mk(1,1,2'b00,0,0, 0,0,0,0,3'd3,0));
        vecs.push_back(mk(1,1,2'b00,0,0, 0,0,0,0,3'd6,0));
        vecs.push_back(mk(0,0,2'b10,0,0, 1,1,0,0,3'd6,1));
        vecs.push_back(mk(0,1,2'b00,0,0, 1,1,0,1,3'd6,1));
        vecs.push_back(mk(0,0,2'b00,0,1, 0,1,1,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,1,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,1,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd0,0));
        // credit 4, cancel beats sel_req; pulses at k, k+2, k+4, k+6; IDLE at k+7
        vecs.push_back(mk(0,1,2'b00,0,0, 0,1,0,0,3'd2,0));
        vecs.push_back(mk(0,1,2'b00,0,0, 0,1,0,0,3'd4,0));
        vecs.push_back(mk(0,0,2'b10,1,0, 0,1,1,0,3'd4,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b11,1,0, 0,1,1,0,3'd3,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,1,0,3'd2,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,1,0,3'd1,1));
        vecs.push_back(mk(0,0,2'b00,0,0, 0,1,0,0,3'd0,0));

        idle_inputs();
        reset = 1'b1;
        #12;
        check("reset_state", outs(), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // inactivity timeout: 16 CREDIT cycles, then CHANGE pays back 2
        @(negedge clk);
        idle_inputs();
        coin_one = 1'b1;
        @(posedge clk);
        #1;
        coin_one = 1'b0;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) begin
                done = 1'b1;
                break;
            end
            if (credit == 3'd2) cnt++;
            @(posedge clk);
            #1;
        end
        check("timeout_reached", {7'd0, done}, 8'd1);
        check("timeout_cycles", 8'(cnt), 8'd16);
        check("timeout_first_change", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1});
        pulses = 0;
        done   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (change_pulse) pulses++;
            @(posedge clk);
            #1;
        end
        check("timeout_drain_done", {7'd0, done}, 8'd1);
        check("timeout_pulses", 8'(pulses), 8'd2);
        check("timeout_idle", outs(), {1'b0, 1'b1, 6'b0});

        // reset during CHANGE with credit 3
        @(negedge clk);
        coin_half = 1'b1;
        coin_one  = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        check("rst_seq_credit3", outs(), {4'b0100, 3'd3, 1'b0});
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("rst_seq_change", outs(), {4'b0110, 3'd3, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_clear", outs(), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_after_%0d", i), outs(), 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the coin-credit path of the vending machine. It accumulates half-unit coin credit, arbitrates between two product-select buttons, and hands a vend request to the dispense mechanism with a valid/ready handshake. It then returns change one half-unit pulse at a time, and refunds on cancel or inactivity timeout. It sits between the coin/button front end and the dispense and change mechanisms.

## Interface
Parameters:
- PRICE, 3 — product price in half-units (3 = 1.50); 1 ≤ PRICE ≤ MAX_CREDIT
- MAX_CREDIT, 6 — credit ceiling in half-units; ≤ 7
- TIMEOUT, 16 — idle cycles in CREDIT before auto-refund; ≥ 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_half  in  1  one-cycle pulse, 0.50 coin (1 half-unit)
- coin_one  in  1  one-cycle pulse, 1.00 coin (2 half-units)
- sel_req  in  2  product-select requests, bit i = item i, level
- cancel  in  1  refund request, one-cycle pulse
- vend_ready  in  1  dispense mechanism accepts request
- vend_valid  out  1  vend request pending
- vend_item  out  1  item index, stable while vend_valid
- change_pulse  out  1  one half-unit returned per high cycle
- coin_reject  out  1  one-cycle pulse: coin(s) of previous cycle rejected
- credit  out  3  current credit in half-units
- busy  out  1  state is VEND or CHANGE

## Operation
- Reset: state IDLE, credit 0, all outputs 0, RR pointer favours item 0. Reset mid-operation discards credit; no change is paid.
- Coin acceptance, in IDLE/CREDIT only:
  - incoming value = coin_half + 2·coin_one, so both coins in the same cycle give 3;
  - if credit + value ≤ MAX_CREDIT, add value; otherwise reject the whole cycle's value and pulse coin_reject;
  - any coin in VEND/CHANGE is rejected.
- IDLE: accepted coin → CREDIT. sel_req and cancel are ignored.
- CREDIT:
  - cancel → CHANGE. cancel beats sel_req in the same cycle.
  - A sel_req with credit ≥ PRICE, where credit is the pre-coin value of that cycle → grant → VEND. vend_item latches the granted index.
  - If both bits request, grant the RR-favoured item; after any grant the pointer favours the other item.
  - A sel_req with insufficient credit is ignored.
  - A coin arriving in the grant cycle is still accepted, subject to the overflow rule.
  - Timeout counter clears on entry, on any accepted coin, and on any grant. It increments otherwise. Reaching TIMEOUT → CHANGE.
- VEND:
  - vend_valid high; vend_item is held.
  - On vend_valid && vend_ready: credit −= PRICE; go to CHANGE if the remainder is > 0, otherwise IDLE.
  - cancel is ignored.
- CHANGE:
  - change_pulse is high on the first CHANGE cycle and then every second cycle.
  - Each pulse decrements credit by 1.
  - The pulse that brings credit to 0 moves the state to IDLE.
  - cancel and sel_req are ignored.
- Arithmetic: credit is unsigned 3-bit and never wraps. This is guaranteed by the overflow rule and by the PRICE ≤ credit check.

## Timing
- All outputs are registered. Coin at cycle n → credit updated at n+1; coin_reject at n+1.
- Grant at cycle n → vend_valid=1 at n+1.
- Handshake at cycle m → vend_valid=0, credit reduced, state CHANGE/IDLE, all at m+1.
- vend_ready while vend_valid=0 has no effect.
- Change: with N half-units to return, pulses occur at cycles k, k+2, …, k+2(N−1), where k is the first CHANGE cycle. credit falls at each pulse+1; state IDLE at k+2N−1.
- Timeout: the TIMEOUT-th consecutive inactive CREDIT cycle → first CHANGE cycle follows.

## Structure
- Package vend_pkg holds:
  - typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} vend_state_t;
  - localparam CREDIT_W = 3;
  - the coin value constants HALF = 1 and ONE = 2.
- Sub-module vend_rr_arb2: 2-request round-robin arbiter with grant-enable, one-hot grant and pointer update.

## Test plan
- Defaults: coin_one, coin_one (credit 4), sel_req=01 → vend_valid, vend_item=0; vend_ready after 2 cycles → credit 1, one change_pulse, IDLE.
- sel_req=11 at credit 3, twice across two vends → first vend_item=0, second vend_item=1; credit 2 with sel_req held → no vend.
- Credit 5, then coin_one → coin_reject next cycle, credit stays 5. Coin_half+coin_one at credit 3 → credit 6.
- Credit 4, cancel together with sel_req=10 → no vend; change_pulse at k, k+2, k+4, k+6; credit 0 and IDLE at k+7.
- Credit 2 with no activity → CHANGE after exactly 16 idle cycles. A coin during VEND → rejected, credit unchanged.
- Assert reset during CHANGE with credit 3 → next cycle all outputs 0 and IDLE; no further change_pulse.
